// File: rtl/lc3_ctrl_pkg.sv
// Shared encodings for the LC-3 control unit: FSM states, datapath mux selects, opcodes.
package lc3_ctrl_pkg;

  typedef enum logic [4:0] {
    ST_HALTED,
    ST_18, ST_33, ST_35, ST_32,
    ST_01, ST_05, ST_09,
    ST_00, ST_22,
    ST_12,
    ST_04, ST_21,
    ST_06, ST_25, ST_27,
    ST_07, ST_23, ST_16,
    ST_PAUSE_A, ST_PAUSE_B
  } state_t;

  localparam logic [1:0] PCMUX_INC  = 2'b00;
  localparam logic [1:0] PCMUX_BUS  = 2'b01;
  localparam logic [1:0] PCMUX_ADDR = 2'b10;

  localparam logic [1:0] ADDR2_ZERO  = 2'b00;
  localparam logic [1:0] ADDR2_OFF6  = 2'b01;
  localparam logic [1:0] ADDR2_OFF9  = 2'b10;
  localparam logic [1:0] ADDR2_OFF11 = 2'b11;

  localparam logic [1:0] ALUK_ADD  = 2'b00;
  localparam logic [1:0] ALUK_AND  = 2'b01;
  localparam logic [1:0] ALUK_NOT  = 2'b10;
  localparam logic [1:0] ALUK_PASS = 2'b11;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  // States that hold an SRAM strobe for MEM_WAIT cycles.
  function automatic logic is_mem_state(state_t s);
    return (s == ST_33) || (s == ST_25) || (s == ST_16);
  endfunction

endpackage

// File: rtl/lc3_control_if.sv
// Control/datapath boundary: status fed back into the sequencer and every control line it drives.
interface lc3_control_if;
  logic       Run;
  logic       Continue;
  logic [3:0] Opcode;
  logic       IR_5;
  logic       IR_11;
  logic       BEN;

  logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX;
  logic MIO_EN;
  logic Mem_OE, Mem_WE;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN,
    output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    output GatePC, GateMDR, GateALU, GateMARMUX,
    output PCMUX, ADDR2MUX, ALUK,
    output DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
    output MIO_EN, Mem_OE, Mem_WE
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN,
    input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
    input  PCMUX, ADDR2MUX, ALUK,
    input  DRMUX, SR1MUX, SR2MUX, ADDR1MUX,
    input  MIO_EN, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/lc3_wait_timer.sv
// Memory-access wait counter: cleared on entry to a memory state, done on its last cycle.
module lc3_wait_timer #(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  logic [2:0] count;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 3'd1;
    end
  end

  assign done = (count == 3'(MEM_WAIT - 1));

endmodule

// File: rtl/lc3_control.sv
// LC-3 instruction sequencer: Moore FSM driving datapath loads, bus gates, mux selects and SRAM strobes.
module lc3_control
  import lc3_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic Clk,
  input  logic Reset,
  lc3_control_if.master bus
);

  state_t state, next_state;
  logic   wait_done, wait_clear, wait_enable;
  logic   ir5_q;
  logic   unused_ir11;

  assign unused_ir11 = bus.IR_11;

  // Timer restarts only when a memory state is freshly entered.
  assign wait_enable = is_mem_state(state);
  assign wait_clear  = is_mem_state(next_state) && (next_state != state);

  lc3_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .Clk    (Clk),
    .Reset  (Reset),
    .clear  (wait_clear),
    .enable (wait_enable),
    .done   (wait_done)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= ST_HALTED;
    else       state <= next_state;
  end

  // IR_5 is registered at decode so SR2MUX stays a function of state, not of live inputs.
  always_ff @(posedge Clk) begin
    if (state == ST_32) ir5_q <= bus.IR_5;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_HALTED:  if (bus.Run) next_state = ST_18;
      ST_18:      next_state = ST_33;
      ST_33:      if (wait_done) next_state = ST_35;
      ST_35:      next_state = ST_32;
      ST_32: begin
        case (bus.Opcode)
          OP_ADD:   next_state = ST_01;
          OP_AND:   next_state = ST_05;
          OP_NOT:   next_state = ST_09;
          OP_BR:    next_state = ST_00;
          OP_JMP:   next_state = ST_12;
          OP_JSR:   next_state = ST_04;
          OP_LDR:   next_state = ST_06;
          OP_STR:   next_state = ST_07;
          OP_PAUSE: next_state = ST_PAUSE_A;
          default:  next_state = ST_18;
        endcase
      end
      ST_01, ST_05, ST_09: next_state = ST_18;
      ST_00:      next_state = bus.BEN ? ST_22 : ST_18;
      ST_22:      next_state = ST_18;
      ST_12:      next_state = ST_18;
      ST_04:      next_state = ST_21;
      ST_21:      next_state = ST_18;
      ST_06:      next_state = ST_25;
      ST_25:      if (wait_done) next_state = ST_27;
      ST_27:      next_state = ST_18;
      ST_07:      next_state = ST_23;
      ST_23:      next_state = ST_16;
      ST_16:      if (wait_done) next_state = ST_18;
      ST_PAUSE_A: if (bus.Continue) next_state = ST_PAUSE_B;
      ST_PAUSE_B: if (!bus.Continue) next_state = ST_18;
      default:    next_state = ST_HALTED;
    endcase
  end

  always_comb begin
    bus.LD_MAR     = 1'b0;
    bus.LD_MDR     = 1'b0;
    bus.LD_IR      = 1'b0;
    bus.LD_BEN     = 1'b0;
    bus.LD_CC      = 1'b0;
    bus.LD_REG     = 1'b0;
    bus.LD_PC      = 1'b0;
    bus.LD_LED     = 1'b0;
    bus.GatePC     = 1'b0;
    bus.GateMDR    = 1'b0;
    bus.GateALU    = 1'b0;
    bus.GateMARMUX = 1'b0;
    bus.PCMUX      = PCMUX_INC;
    bus.ADDR2MUX   = ADDR2_ZERO;
    bus.ALUK       = ALUK_ADD;
    bus.DRMUX      = 1'b0;
    bus.SR1MUX     = 1'b0;
    bus.SR2MUX     = 1'b0;
    bus.ADDR1MUX   = 1'b0;
    bus.MIO_EN     = 1'b0;
    bus.Mem_OE     = 1'b1;
    bus.Mem_WE     = 1'b1;
    case (state)
      ST_18: begin
        bus.GatePC = 1'b1;
        bus.LD_MAR = 1'b1;
        bus.PCMUX  = PCMUX_INC;
        bus.LD_PC  = 1'b1;
      end
      ST_33, ST_25: begin
        bus.Mem_OE = 1'b0;
        bus.MIO_EN = 1'b1;
        bus.LD_MDR = wait_done;
      end
      ST_35, ST_27: begin
        bus.GateMDR = 1'b1;
        bus.LD_IR   = (state == ST_35);
        bus.LD_REG  = (state == ST_27);
        bus.LD_CC   = (state == ST_27);
      end
      ST_32: bus.LD_BEN = 1'b1;
      ST_01, ST_05, ST_09: begin
        bus.SR1MUX  = 1'b1;
        bus.SR2MUX  = (state == ST_09) ? 1'b0 : ir5_q;
        bus.ALUK    = (state == ST_01) ? ALUK_ADD :
                      (state == ST_05) ? ALUK_AND : ALUK_NOT;
        bus.GateALU = 1'b1;
        bus.LD_REG  = 1'b1;
        bus.LD_CC   = 1'b1;
      end
      ST_22: begin
        bus.ADDR1MUX = 1'b0;
        bus.ADDR2MUX = ADDR2_OFF9;
        bus.PCMUX    = PCMUX_ADDR;
        bus.LD_PC    = 1'b1;
      end
      ST_12: begin
        bus.SR1MUX  = 1'b1;
        bus.ALUK    = ALUK_PASS;
        bus.GateALU = 1'b1;
        bus.PCMUX   = PCMUX_BUS;
        bus.LD_PC   = 1'b1;
      end
      ST_04: begin
        bus.GatePC = 1'b1;
        bus.DRMUX  = 1'b1;
        bus.LD_REG = 1'b1;
      end
      ST_21: begin
        bus.ADDR2MUX = ADDR2_OFF11;
        bus.PCMUX    = PCMUX_ADDR;
        bus.LD_PC    = 1'b1;
      end
      ST_06, ST_07: begin
        bus.SR1MUX     = 1'b1;
        bus.ADDR1MUX   = 1'b1;
        bus.ADDR2MUX   = ADDR2_OFF6;
        bus.GateMARMUX = 1'b1;
        bus.LD_MAR     = 1'b1;
      end
      ST_23: begin
        bus.SR1MUX  = 1'b0;
        bus.ALUK    = ALUK_PASS;
        bus.GateALU = 1'b1;
        bus.MIO_EN  = 1'b0;
        bus.LD_MDR  = 1'b1;
      end
      ST_16:      bus.Mem_WE = 1'b0;
      ST_PAUSE_A,
      ST_PAUSE_B: bus.LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lc3_control.sv
// Directed bench for lc3_control: per-instruction expected control-word sequences checked every cycle.
module tb_lc3_control;

  localparam int MW = 3;

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux, addr2mux, aluk;
    logic drmux, sr1mux, sr2mux, addr1mux, mio_en, mem_oe, mem_we;
  } ctl_t;

  logic Clk;
  logic Reset;
  lc3_control_if bus();

  lc3_control #(.MEM_WAIT(MW)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int ncyc = 0, oe_cnt = 0, we_cnt = 0, led_cnt = 0, mdr_cnt = 0;

  ctl_t  exp_q[$];
  string name_q[$];
  ctl_t  plan_q[$];
  string plan_n[$];
  ctl_t  ce, cg;
  string cn;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic ctl_t dflt();
    ctl_t c;
    c = '0;
    c.mem_oe = 1'b1;
    c.mem_we = 1'b1;
    return c;
  endfunction

  function automatic ctl_t dut_ctl();
    ctl_t c;
    c = {bus.LD_MAR, bus.LD_MDR, bus.LD_IR, bus.LD_BEN, bus.LD_CC, bus.LD_REG, bus.LD_PC, bus.LD_LED,
         bus.GatePC, bus.GateMDR, bus.GateALU, bus.GateMARMUX,
         bus.PCMUX, bus.ADDR2MUX, bus.ALUK,
         bus.DRMUX, bus.SR1MUX, bus.SR2MUX, bus.ADDR1MUX, bus.MIO_EN, bus.Mem_OE, bus.Mem_WE};
    return c;
  endfunction

  // Compare process: every queued expectation is checked at the falling edge of its cycle.
  always @(negedge Clk) begin
    cg = dut_ctl();
    ncyc++;
    if (!bus.Mem_OE) oe_cnt++;
    if (!bus.Mem_WE) we_cnt++;
    if (bus.LD_LED)  led_cnt++;
    if (bus.LD_MDR)  mdr_cnt++;
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      cn = name_q.pop_front();
      checks++;
      if (cg !== ce) begin
        errors++;
        $display("FAIL %s: got %h expected %h", cn, cg, ce);
      end
    end
  end

  task automatic lit(input string n, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, got, expv);
    end
  endtask

  task automatic tick(input ctl_t e, input string n);
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input ctl_t c, input string n);
    plan_q.push_back(c);
    plan_n.push_back(n);
  endtask

  // Reference sequence for one instruction, starting with its first fetch cycle.
  task automatic build_plan(input logic [3:0] op, input logic ir5, input logic ben);
    ctl_t c;
    plan_q.delete();
    plan_n.delete();
    c = dflt(); c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; add(c, "fetch_pc");
    for (int i = 0; i < MW; i++) begin
      c = dflt(); c.mem_oe = 0; c.mio_en = 1; c.ld_mdr = (i == MW - 1); add(c, "fetch_rd");
    end
    c = dflt(); c.gate_mdr = 1; c.ld_ir = 1; add(c, "fetch_ir");
    c = dflt(); c.ld_ben = 1; add(c, "decode");
    case (op)
      4'b0001, 4'b0101, 4'b1001: begin
        c = dflt(); c.sr1mux = 1; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
        c.aluk   = (op == 4'b0001) ? 2'b00 : (op == 4'b0101) ? 2'b01 : 2'b10;
        c.sr2mux = (op == 4'b1001) ? 1'b0 : ir5;
        add(c, "alu");
      end
      4'b0000: begin
        add(dflt(), "br");
        if (ben) begin
          c = dflt(); c.addr2mux = 2'b10; c.pcmux = 2'b10; c.ld_pc = 1; add(c, "br_taken");
        end
      end
      4'b1100: begin
        c = dflt(); c.sr1mux = 1; c.aluk = 2'b11; c.gate_alu = 1; c.pcmux = 2'b01; c.ld_pc = 1;
        add(c, "jmp");
      end
      4'b0100: begin
        c = dflt(); c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; add(c, "jsr_link");
        c = dflt(); c.addr2mux = 2'b11; c.pcmux = 2'b10; c.ld_pc = 1; add(c, "jsr_pc");
      end
      4'b0110, 4'b0111: begin
        c = dflt(); c.sr1mux = 1; c.addr1mux = 1; c.addr2mux = 2'b01; c.gate_marmux = 1; c.ld_mar = 1;
        add(c, "ea");
        if (op == 4'b0110) begin
          for (int i = 0; i < MW; i++) begin
            c = dflt(); c.mem_oe = 0; c.mio_en = 1; c.ld_mdr = (i == MW - 1); add(c, "ldr_rd");
          end
          c = dflt(); c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; add(c, "ldr_wb");
        end else begin
          c = dflt(); c.aluk = 2'b11; c.gate_alu = 1; c.ld_mdr = 1; add(c, "str_mdr");
          for (int i = 0; i < MW; i++) begin
            c = dflt(); c.mem_we = 0; add(c, "str_wr");
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic run_instr(input logic [3:0] op, input logic ir5, input logic ben,
                           input string tag, input int exp_cycles);
    int start;
    bus.Opcode = op;
    bus.IR_5   = ir5;
    bus.BEN    = ben;
    build_plan(op, ir5, ben);
    lit({tag, "_len"}, plan_q.size(), exp_cycles);
    start = ncyc;
    while (plan_q.size() > 0) tick(plan_q.pop_front(), {tag, "_", plan_n.pop_front()});
    lit({tag, "_cycles"}, ncyc - start, exp_cycles);
  endtask

  task automatic run_pause(input int na, input int nb);
    ctl_t c;
    int led0;
    bus.Opcode   = 4'b1101;
    bus.Continue = 1'b0;
    build_plan(4'b1101, 1'b0, 1'b0);
    while (plan_q.size() > 0) tick(plan_q.pop_front(), {"pause_", plan_n.pop_front()});
    led0 = led_cnt;
    c = dflt(); c.ld_led = 1;
    for (int i = 0; i < na; i++) begin
      if (i == na - 1) bus.Continue = 1'b1;
      tick(c, "pause_a");
    end
    for (int i = 0; i < nb; i++) begin
      if (i == nb - 1) bus.Continue = 1'b0;
      tick(c, "pause_b");
    end
    lit("pause_led_cycles", led_cnt - led0, na + nb);
  endtask

  initial begin
    int oe0, we0, mdr0;
    Reset = 1'b1;
    bus.Run = 0; bus.Continue = 0; bus.Opcode = 4'b0000;
    bus.IR_5 = 0; bus.IR_11 = 0; bus.BEN = 0;
    @(posedge Clk); @(posedge Clk); #1;
    Reset = 1'b0;
    lit("rst_mem_oe", bus.Mem_OE, 1);
    lit("rst_mem_we", bus.Mem_WE, 1);
    lit("rst_ld_pc",  bus.LD_PC, 0);
    tick(dflt(), "halted_idle");
    bus.Run = 1'b1;
    tick(dflt(), "halted_run");
    lit("s18_gate_pc", bus.GatePC, 1);
    lit("s18_ld_mar",  bus.LD_MAR, 1);

    oe0 = oe_cnt;
    bus.Continue = 1'b1;
    run_instr(4'b0001, 1'b1, 1'b0, "add_imm", 7);
    bus.Continue = 1'b0;
    lit("fetch_oe_cycles", oe_cnt - oe0, 3);
    run_instr(4'b0101, 1'b0, 1'b0, "and_reg", 7);
    run_instr(4'b1001, 1'b1, 1'b0, "not", 7);
    run_instr(4'b0000, 1'b0, 1'b0, "br_nt", 7);
    run_instr(4'b0000, 1'b0, 1'b1, "br_t", 8);
    run_instr(4'b1100, 1'b0, 1'b0, "jmp", 7);
    bus.IR_11 = 1'b1;
    run_instr(4'b0100, 1'b0, 1'b0, "jsr", 8);
    bus.IR_11 = 1'b0;
    oe0 = oe_cnt;
    run_instr(4'b0110, 1'b0, 1'b0, "ldr", 11);
    lit("ldr_oe_cycles", oe_cnt - oe0, 6);
    we0 = we_cnt;
    run_instr(4'b0111, 1'b0, 1'b1, "str", 11);
    lit("str_we_cycles", we_cnt - we0, 3);
    run_instr(4'b1111, 1'b0, 1'b0, "nop", 6);
    run_pause(3, 2);
    run_instr(4'b0001, 1'b0, 1'b0, "add_reg", 7);

    // LDR aborted by reset in the second cycle of its memory read.
    bus.Opcode = 4'b0110;
    build_plan(4'b0110, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) tick(plan_q.pop_front(), {"abort_", plan_n.pop_front()});
    mdr0 = mdr_cnt;
    tick(plan_q.pop_front(), {"abort_", plan_n.pop_front()});
    tick(plan_q.pop_front(), {"abort_", plan_n.pop_front()});
    Reset = 1'b1;
    bus.Run = 1'b0;
    tick(plan_q.pop_front(), {"abort_", plan_n.pop_front()});
    Reset = 1'b0;
    lit("abort_mem_oe", bus.Mem_OE, 1);
    lit("abort_mio_en", bus.MIO_EN, 0);
    tick(dflt(), "abort_halted");
    tick(dflt(), "abort_halted2");
    lit("abort_no_ld_mdr", mdr_cnt - mdr0, 0);
    bus.Run = 1'b1;
    tick(dflt(), "restart_halted");
    run_instr(4'b0001, 1'b1, 1'b0, "add_after_rst", 7);

    lit("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/lc3_control.md
# lc3_control

Instruction-sequencing FSM for the LC-3 datapath. It decodes the opcode and condition bits fed back from the datapath, then drives every load enable, bus gate, mux select and memory strobe the datapath consumes. Memory accesses are held for a parameterised number of wait cycles. It also implements the PAUSE debug instruction (LED display plus Continue handshake) and sits between the top-level switches/buttons and the datapath.

## Interface
Parameters:
- MEM_WAIT, 2: cycles Mem_OE/Mem_WE held asserted per access (range 1..7).

Ports:
- Clk  input  1  system clock; all state changes on posedge.
- Reset  input  1  synchronous, active-high; forces Halted.
- Run  input  1  start execution from Halted (level).
- Continue  input  1  release from PAUSE (level, debounced upstream).
- Opcode  input  4  IR[15:12].
- IR_5  input  1  imm/register select bit for ADD/AND.
- IR_11  input  1  reserved (JSRR unsupported; ignored).
- BEN  input  1  registered branch-enable from datapath.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  output  1 each  register load enables.
- GatePC, GateMDR, GateALU, GateMARMUX  output  1 each  bus drivers; at most one high per cycle.
- PCMUX, ADDR2MUX, ALUK  output  2 each  selects.
- DRMUX, SR1MUX, SR2MUX, ADDR1MUX  output  1 each  selects.
- MIO_EN  output  1  1 = MDR loads memory data, 0 = MDR loads BUS.
- Mem_OE, Mem_WE  output  1 each  active-low SRAM strobes.

## Operation
- Encodings: PCMUX 00 PC+1, 01 BUS, 10 address adder; ADDR2MUX 00 zero, 01 SEXT(IR[5:0]), 10 SEXT(IR[8:0]), 11 SEXT(IR[10:0]); ADDR1MUX 0 PC, 1 SR1; DRMUX 0 IR[11:9], 1 R7; SR1MUX 0 IR[11:9], 1 IR[8:6]; SR2MUX = IR_5; ALUK 00 ADD, 01 AND, 10 NOT, 11 PASS.
- Default each cycle: every enable/gate 0, selects 0, Mem_OE = Mem_WE = 1, MIO_EN = 0.
- Halted: Run=1 -> S18.
- S18: GatePC, LD_MAR, PCMUX=00, LD_PC -> S33.
- S33: Mem_OE=0, MIO_EN=1 for MEM_WAIT cycles; LD_MDR only on last cycle -> S35.
- S35: GateMDR, LD_IR -> S32.
- S32: LD_BEN; dispatch on Opcode: 0001 S01, 0101 S05, 1001 S09, 0000 S00, 1100 S12, 0100 S04, 0110 S06, 0111 S07, 1101 PauseA; any other opcode -> S18 (NOP).
- S01/S05/S09: SR1MUX=1, ALUK ADD/AND/NOT, GateALU, LD_REG, LD_CC -> S18.
- S00: BEN ? S22 : S18. S22: ADDR1MUX=0, ADDR2MUX=10, PCMUX=10, LD_PC -> S18.
- S12: SR1MUX=1, ALUK=PASS, GateALU, PCMUX=01, LD_PC -> S18.
- S04: GatePC, DRMUX=1, LD_REG -> S21: ADDR2MUX=11, PCMUX=10, LD_PC -> S18.
- S06: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=01, GateMARMUX, LD_MAR -> S25 (as S33) -> S27: GateMDR, LD_REG, LD_CC -> S18.
- S07: as S06 -> S23: SR1MUX=0, ALUK=PASS, GateALU, MIO_EN=0, LD_MDR -> S16: Mem_WE=0 for MEM_WAIT cycles -> S18.
- PauseA: LD_LED=1; Continue=1 -> PauseB. PauseB: LD_LED=1; Continue=0 -> S18.

## Timing
- Reset at posedge: state Halted, wait counter 0, all outputs at default (strobes high) next cycle; applies mid-access, aborting strobes immediately.
- Outputs purely from current state (Moore); no input-to-output combinational path.
- Wait counter: 3-bit; cleared on entering S33/S25/S16, increments each cycle in them, exit when count = MEM_WAIT-1.
- Cycles per instruction (MEM_WAIT=2): fetch 5 (S18, S33×2, S35, S32); ADD +1; BR taken +2, not taken +1; JSR +2; LDR +4; STR +4.
- Run ignored outside Halted; Continue ignored outside Pause states.

## Structure
- Package lc3_ctrl_pkg: state enum, PCMUX/ADDR2MUX/ALUK encodings, opcode constants.
- Sub-module lc3_wait_timer: clear/enable/done counter used by the three memory states.

## Test plan
- Reset then Run=1 -> Halted for 1 cycle after Run, then S18 with GatePC=LD_MAR=LD_PC=1; Mem_OE low exactly 2 cycles.
- Opcode 0001, IR_5=1 -> S01 cycle: ALUK=00, SR2MUX=1, LD_REG=LD_CC=1, back to S18 next.
- Opcode 0000, BEN=0 -> S00 then S18; BEN=1 -> S22 with PCMUX=10, ADDR2MUX=10, LD_PC=1.
- Opcode 0111, MEM_WAIT=3 -> S07, S23 (MIO_EN=0, LD_MDR=1), Mem_WE low exactly 3 cycles, then S18.
- Opcode 1101 -> LD_LED held until Continue pulses high then low; then S18.
- Reset asserted in 2nd S25 cycle -> next cycle Halted, Mem_OE=1, LD_MDR never asserted.
